// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks (score_keeper, ball_movement).
// Holds the playfield geometry, game rules, the score_keeper state encoding,
// and a saturating score-increment helper.
package pong_pkg;

  localparam int unsigned FIELD_W     = 64;  // playfield width in ball units
  localparam int unsigned CENTER      = 31;  // ball recentre column
  localparam int unsigned WIN_SCORE   = 11;  // points needed to win (1..15)
  localparam int unsigned SERVE_DELAY = 60;  // ticks before each serve (1..255)

  localparam int unsigned BX_W    = 6;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned TIMER_W = 8;

  // score_keeper state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SERVE_WAIT = 2'd1;
  localparam logic [1:0] ST_PLAY       = 2'd2;
  localparam logic [1:0] ST_GAME_OVER  = 2'd3;

  // Add one point but never pass the winning score, so a score can never
  // wrap even if the FSM were somehow left in play after a win.
  function automatic logic [SCORE_W-1:0] score_inc(
    input logic [SCORE_W-1:0] s,
    input int unsigned        win
  );
    if (int'(s) >= int'(win))
      return s;
    return s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/serve_timer.sv
// Serve countdown: 8-bit down counter.
//   clk   : system clock
//   reset : synchronous active-high reset (counter cleared to 0)
//   load  : reload counter with DELAY (has priority over tick)
//   tick  : decrement enable (already gated by the caller)
//   done  : combinational, high on a tick that consumes the last count
module serve_timer
  import pong_pkg::*;
#(
  parameter int unsigned DELAY = SERVE_DELAY
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= TIMER_W'(DELAY);
    else if (tick && (count != '0))
      count <= count - TIMER_W'(1);
  end

  assign done = tick && !load && (count == TIMER_W'(1));

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: runs the serve countdown, detects goals, keeps both
// scores and declares the winner. All outputs are registered.
//   clk, reset  : system clock, synchronous active-high reset
//   tick        : frame-rate enable; game events are sampled only on tick
//   start       : start-button pulse (honoured in IDLE and GAME_OVER)
//   bx          : ball x position
//   sc1, sc2    : player-1 (right goal) / player-2 (left goal) scores
//   score_pulse : one-cycle pulse per point
//   serve_go    : one-cycle pulse releasing the serve
//   serve_dir   : 0 = serve toward right, 1 = toward left
//   ball_hold   : ball frozen at centre
//   game_over   : game finished; winner valid (0 = player 1, 1 = player 2)
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned FIELD_W     = pong_pkg::FIELD_W,
  parameter int unsigned WIN_SCORE   = pong_pkg::WIN_SCORE,
  parameter int unsigned SERVE_DELAY = pong_pkg::SERVE_DELAY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [BX_W-1:0]    bx,
  output logic [SCORE_W-1:0] sc1,
  output logic [SCORE_W-1:0] sc2,
  output logic               score_pulse,
  output logic               serve_go,
  output logic               serve_dir,
  output logic               ball_hold,
  output logic               game_over,
  output logic               winner
);

  logic [1:0]         state;
  logic               timer_load;
  logic               timer_tick;
  logic               timer_done;
  logic               point_left;
  logic               point_right;
  logic [SCORE_W-1:0] sc1_inc;
  logic [SCORE_W-1:0] sc2_inc;
  logic               win_left;
  logic               win_right;
  logic               new_game;

  // Left goal is checked first so that a degenerate field where both goal
  // conditions hold scores only for player 2.
  assign point_left  = (state == ST_PLAY) && tick && (bx == '0);
  assign point_right = (state == ST_PLAY) && tick && (bx != '0) &&
                       (int'(bx) >= int'(FIELD_W) - 1);

  assign sc1_inc   = score_inc(sc1, WIN_SCORE);
  assign sc2_inc   = score_inc(sc2, WIN_SCORE);
  assign win_left  = (int'(sc2_inc) == int'(WIN_SCORE));
  assign win_right = (int'(sc1_inc) == int'(WIN_SCORE));

  assign new_game = start && ((state == ST_IDLE) || (state == ST_GAME_OVER));

  assign timer_tick = tick && (state == ST_SERVE_WAIT);
  assign timer_load = new_game ||
                      (point_left && !win_left) ||
                      (point_right && !win_right);

  serve_timer #(
    .DELAY (SERVE_DELAY)
  ) u_serve_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .tick  (timer_tick),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sc1         <= '0;
      sc2         <= '0;
      score_pulse <= 1'b0;
      serve_go    <= 1'b0;
      serve_dir   <= 1'b0;
      ball_hold   <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      serve_go    <= 1'b0;
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            sc1       <= '0;
            sc2       <= '0;
            serve_dir <= 1'b0;
            ball_hold <= 1'b1;
            game_over <= 1'b0;
            winner    <= 1'b0;
            state     <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          if (timer_done) begin
            serve_go  <= 1'b1;
            ball_hold <= 1'b0;
            state     <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (point_left) begin
            sc2         <= sc2_inc;
            serve_dir   <= 1'b1;
            score_pulse <= 1'b1;
            ball_hold   <= 1'b1;
            if (win_left) begin
              game_over <= 1'b1;
              winner    <= 1'b1;
              state     <= ST_GAME_OVER;
            end else begin
              state     <= ST_SERVE_WAIT;
            end
          end else if (point_right) begin
            sc1         <= sc1_inc;
            serve_dir   <= 1'b0;
            score_pulse <= 1'b1;
            ball_hold   <= 1'b1;
            if (win_right) begin
              game_over <= 1'b1;
              winner    <= 1'b0;
              state     <= ST_GAME_OVER;
            end else begin
              state     <= ST_SERVE_WAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
